// File: rtl/tdc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tdc_ctrl_pkg
// Shared types and helpers for the multi-channel TDC latch controller:
//   - per-channel FSM state encoding
//   - per-channel edge-mode codes (edge_sel field values)
//   - dead-counter width helper
// No ports (package).
// -----------------------------------------------------------------------------
package tdc_ctrl_pkg;

    // Per-channel controller state
    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        LATCH   = 2'd1,
        WAIT_RD = 2'd2,
        DEAD    = 2'd3
    } chan_state_t;

    // Edge qualification mode, one 2-bit field per channel
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    // Synchroniser depth used when the sync stage is enabled
    localparam int unsigned SYNC_STAGES = 2;

    // Dead counter only ever holds 0 .. dead_cyc-1
    function automatic int unsigned dead_cnt_w(input int unsigned dead_cyc);
        if (dead_cyc <= 1) begin
            return 1;
        end
        return $clog2(dead_cyc);
    endfunction

endpackage

// File: rtl/tdc_latch_chan.sv
// -----------------------------------------------------------------------------
// tdc_latch_chan
// One TDC channel: optional input synchroniser, selectable edge detect,
// ARMED/LATCH/WAIT_RD/DEAD controller, dead-time counter and saturating
// missed-edge counter. All outputs are registered.
//
// Optional feature: define TDC_LATCH_SYNC_EN to insert a 2-flop synchroniser
// on i_hit ahead of edge detection (+2 cycles latency).
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   i_hit       hit/clear input for this channel
//   i_edge_sel  edge mode (edge_mode_t encoding)
//   i_rd_ack    readout acknowledge pulse
//   o_latch     one-cycle capture strobe
//   o_pending   latched, awaiting acknowledge
//   o_busy      not armed (LATCH, WAIT_RD or DEAD)
//   o_miss_cnt  saturating count of edges seen while busy
// -----------------------------------------------------------------------------
module tdc_latch_chan
    import tdc_ctrl_pkg::*;
#(
    parameter int unsigned DEAD_CYC = 8,
    parameter int unsigned MISS_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hit,
    input  logic [1:0]        i_edge_sel,
    input  logic              i_rd_ack,
    output logic              o_latch,
    output logic              o_pending,
    output logic              o_busy,
    output logic [MISS_W-1:0] o_miss_cnt
);

    localparam int unsigned     CNT_W     = dead_cnt_w(DEAD_CYC);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);

    chan_state_t       r_state;
    chan_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_dead_cnt;
    logic [CNT_W-1:0]  w_dead_nxt;
    logic [MISS_W-1:0] r_miss_cnt;
    logic [MISS_W-1:0] w_miss_nxt;
    logic              r_latch;
    logic              r_pending;
    logic              r_busy;
    logic              r_prev;
    logic              r_first;
    logic              w_sample;
    logic              w_rise;
    logic              w_fall;
    logic              w_edge_mode;
    logic              w_edge;

`ifdef TDC_LATCH_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;

    // Two-flop synchroniser for asynchronous hits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_hit};
        end
    end

    assign w_sample = r_sync[SYNC_STAGES-1];
`else
    assign w_sample = i_hit;
`endif

    // Edge qualification; r_first masks the first sample after reset so a
    // level held through reset is not mistaken for an edge
    always_comb begin
        w_rise      = w_sample & ~r_prev;
        w_fall      = ~w_sample & r_prev;
        w_edge_mode = 1'b0;
        case (edge_mode_t'(i_edge_sel))
            EDGE_RISE: w_edge_mode = w_rise;
            EDGE_FALL: w_edge_mode = w_fall;
            EDGE_BOTH: w_edge_mode = w_rise | w_fall;
            default:   w_edge_mode = 1'b0;
        endcase
        w_edge = w_edge_mode & ~r_first;
    end

    // Next-state, dead counter and miss counter
    always_comb begin
        w_state_nxt = r_state;
        w_dead_nxt  = r_dead_cnt;
        w_miss_nxt  = r_miss_cnt;

        case (r_state)
            ARMED: begin
                if (w_edge) begin
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                w_state_nxt = WAIT_RD;
            end
            WAIT_RD: begin
                if (i_rd_ack) begin
                    w_state_nxt = DEAD;
                    w_dead_nxt  = DEAD_LOAD;
                end
            end
            DEAD: begin
                if (r_dead_cnt == '0) begin
                    w_state_nxt = ARMED;
                end else begin
                    w_dead_nxt = r_dead_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARMED;
            end
        endcase

        // Edges while busy never restart the channel; they are only counted
        if (w_edge && (r_state != ARMED) && (r_miss_cnt != '1)) begin
            w_miss_nxt = r_miss_cnt + MISS_W'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARMED;
            r_dead_cnt <= '0;
            r_miss_cnt <= '0;
            r_latch    <= 1'b0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b0;
            r_prev     <= 1'b0;
            r_first    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_miss_cnt <= w_miss_nxt;
            r_latch    <= (w_state_nxt == LATCH);
            r_pending  <= (w_state_nxt == WAIT_RD);
            r_busy     <= (w_state_nxt != ARMED);
            r_prev     <= w_sample;
            r_first    <= 1'b0;
        end
    end

    assign o_latch    = r_latch;
    assign o_pending  = r_pending;
    assign o_busy     = r_busy;
    assign o_miss_cnt = r_miss_cnt;

endmodule

// File: rtl/tdc_latch_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_latch_ctrl
// Multi-channel TDC clear/latch pulse generator. Each of N_CH channels detects
// a selectable edge on its hit input, strobes latch for one cycle, holds until
// rd_ack, then waits DEAD_CYC cycles before re-arming. Channels are fully
// independent; this level only slices the buses.
//
// Optional feature: TDC_LATCH_SYNC_EN adds a 2-flop synchroniser per hit bit.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   hit       [N_CH]        per-channel hit/clear inputs
//   edge_sel  [2*N_CH]      per-channel edge mode, bits [2c+1:2c]
//   rd_ack    [N_CH]        per-channel readout acknowledge pulse
//   latch     [N_CH]        per-channel one-cycle capture strobe
//   pending   [N_CH]        latched and awaiting rd_ack
//   busy      [N_CH]        channel not armed
//   miss_cnt  [N_CH*MISS_W] per-channel saturating missed-edge counts
// -----------------------------------------------------------------------------
module tdc_latch_ctrl
    import tdc_ctrl_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned DEAD_CYC = 8,
    parameter int unsigned MISS_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        hit,
    input  logic [2*N_CH-1:0]      edge_sel,
    input  logic [N_CH-1:0]        rd_ack,
    output logic [N_CH-1:0]        latch,
    output logic [N_CH-1:0]        pending,
    output logic [N_CH-1:0]        busy,
    output logic [N_CH*MISS_W-1:0] miss_cnt
);

    localparam int unsigned MODE_W = $bits(edge_mode_t);

    // One independent controller per channel
    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        tdc_latch_chan #(
            .DEAD_CYC (DEAD_CYC),
            .MISS_W   (MISS_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_hit      (hit[c]),
            .i_edge_sel (edge_sel[MODE_W*c +: MODE_W]),
            .i_rd_ack   (rd_ack[c]),
            .o_latch    (latch[c]),
            .o_pending  (pending[c]),
            .o_busy     (busy[c]),
            .o_miss_cnt (miss_cnt[MISS_W*c +: MISS_W])
        );
    end

endmodule
